// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the sequential carry-lookahead adder.
package cla_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int unsigned SLICE_DEFAULT = 16;

   // Width of the slice index register; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned ns);
      int unsigned w;
      if (ns > 1) w = unsigned'($clog2(ns));
      else        w = 1;
      return w;
   endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder built from 4-bit groups.
// Exports the carry into its MSB so the caller can derive signed overflow.
module cla_slice #(
   parameter int unsigned SLICE = 16
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   localparam int unsigned NG = SLICE / 4;

   logic [SLICE-1:0] g;
   logic [SLICE-1:0] p;
   logic [SLICE-1:0] c;
   logic [NG-1:0]    gg;
   logic [NG-1:0]    pg;
   logic [NG:0]      gc;

   assign g = a & b;
   assign p = a ^ b;

   // Per-group generate/propagate and in-group bit carries from the group carry-in.
   for (genvar k = 0; k < NG; k++) begin : g_grp
      localparam int unsigned B = 4 * k;
      assign gg[k]  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign pg[k]  = &p[B+3:B];
      assign c[B]   = gc[k];
      assign c[B+1] = g[B] | (p[B] & gc[k]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & gc[k]);
   end

   // Group-level carry chain driven by group generate/propagate.
   always_comb begin
      gc    = '0;
      gc[0] = cin;
      for (int unsigned k = 0; k < NG; k++) begin
         gc[k+1] = gg[k] | (pg[k] & gc[k]);
      end
   end

   assign sum   = p ^ c;
   assign cout  = gc[NG];
   assign c_msb = c[SLICE-1];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor reusing one SLICE-bit lookahead slice,
// LSB slice first, carry registered between cycles.
// Optional feature macro: CLA_SEQ_OVF_EN adds the signed-overflow output ovf.
module cla_seq_adder
   import cla_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned SLICE = SLICE_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CLA_SEQ_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned  NS   = WIDTH / SLICE;
   localparam int unsigned  IW   = idx_width(NS);
   localparam logic [IW-1:0] LAST = IW'(NS - 1);

   if ((SLICE == 0) || ((WIDTH % SLICE) != 0) || ((SLICE % 4) != 0)) begin : g_bad_cfg
      $error("cla_seq_adder: WIDTH must be a multiple of SLICE and SLICE a multiple of 4");
   end

   state_t                      state_q, state_d;
   logic [NS-1:0][SLICE-1:0]    a_q, b_q, sum_q;
   logic                        carry_q;
   logic [IW-1:0]               idx_q;
   logic [SLICE-1:0]            slice_sum;
   logic                        slice_cout;
   logic                        slice_cmsb;
   logic                        accept;
   logic                        last;

   assign accept = in_valid & in_ready;
   assign last   = (state_q == RUN) && (idx_q == LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last)      state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   cla_slice #(
      .SLICE(SLICE)
   ) u_slice (
      .a     (a_q[idx_q]),
      .b     (b_q[idx_q]),
      .cin   (carry_q),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .c_msb (slice_cmsb)
   );

   // Operand capture at accept, then one slice result and carry per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b ^ {WIDTH{op_sub}};
         carry_q <= cin ^ op_sub;
         sum_q   <= '0;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         sum_q[idx_q] <= slice_sum;
         carry_q      <= slice_cout;
         idx_q        <= last ? '0 : idx_q + 1'b1;
      end
   end

   assign sum  = sum_q;
   assign cout = carry_q;

`ifdef CLA_SEQ_OVF_EN
   logic ovf_q;

   // Overflow captured from the MSB slice in the last RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ovf_q <= 1'b0;
      else if (accept) ovf_q <= 1'b0;
      else if (last)   ovf_q <= slice_cmsb ^ slice_cout;
   end

   assign ovf = ovf_q;
`else
   logic unused_c_msb;
   assign unused_c_msb = slice_cmsb;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder (64-bit, 16-bit slices).
// Overflow checks are active when CLA_SEQ_OVF_EN is defined.
module tb_cla_seq_adder;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned SLICE = 16;
   localparam int unsigned NS    = WIDTH / SLICE;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a         = '0;
   logic [WIDTH-1:0] b         = '0;
   logic             cin       = 1'b0;
   logic             op_sub    = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef CLA_SEQ_OVF_EN
   logic             ovf;
`endif

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             c;
      logic             o;
      int unsigned      acc;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          errors   = 0;
   int unsigned cyc      = 0;
   int unsigned last_acc = 0;
   logic        ov_prev  = 1'b0;

   cla_seq_adder #(
      .WIDTH(WIDTH),
      .SLICE(SLICE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef CLA_SEQ_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: latency on each rising out_valid, result compare on each handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         ov_prev = 1'b0;
      end else begin
         if (out_valid && !ov_prev) begin
            if (sb.size() == 0) chk("unexpected_valid", out_valid, 0);
            else                chk("latency", cyc - sb[0].acc, NS);
         end
         if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            chk("sum", sum, e.s);
            chk("cout", cout, e.c);
`ifdef CLA_SEQ_OVF_EN
            chk("ovf", ovf, e.o);
`endif
         end
         ov_prev = out_valid;
      end
   end

   // Present operands until accepted, then scramble the inputs.
   task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2,
                        input logic tc, input logic ts,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                        input bit push);
      int unsigned n;
      exp_t e;
      n = 0;
      a = ta; b = tb2; cin = tc; op_sub = ts; in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 100) begin
            chk("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      last_acc = cyc;
      e.s = es; e.c = ec; e.o = eo; e.acc = cyc;
      if (push) sb.push_back(e);
      in_valid = 1'b0;
      a = ~ta; b = ~tb2; cin = ~tc; op_sub = ~ts;
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("drain_timeout", sb.size(), 0);
   endtask

   task automatic op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2,
                     input logic tc, input logic ts,
                     input logic [WIDTH-1:0] es, input logic ec, input logic eo);
      issue(ta, tb2, tc, ts, es, ec, eo, 1'b1);
      drain();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},  in_ready,  1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_sum"},       sum,       0);
      chk({tag, "_cout"},      cout,      0);
`ifdef CLA_SEQ_OVF_EN
      chk({tag, "_ovf"},       ovf,       0);
`endif
   endtask

   initial begin
      int unsigned rel;
      int unsigned n;
      int unsigned hs;
      exp_t e;

      #2;
      @(negedge clk);
      chk_reset_vals("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rel   = cyc;

      op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      chk("first_accept_edge", last_acc, rel + 1);
      op(64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      op(64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0);
      op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
         64'h2222_2222_2222_2212, 1'b0, 1'b0);
      op(64'hFFFF, 64'h1, 1'b0, 1'b0, 64'h1_0000, 1'b0, 1'b0);
      op(64'd10, 64'd3, 1'b1, 1'b1, 64'd6, 1'b1, 1'b0);
      op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      op(64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0);

      // Backpressure: result held, new operands offered but not captured.
      out_ready = 1'b0;
      issue(64'h1111, 64'h2222, 1'b0, 1'b0, 64'h3333, 1'b0, 1'b0, 1'b1);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("bp_valid", out_valid, 1);
      a = 64'h100; b = 64'h200; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_sum", sum, 64'h3333);
         chk("bp_hold_valid", out_valid, 1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      hs = cyc;
      chk("bp_idle_in_ready", in_ready, 1);
      chk("bp_valid_dropped", out_valid, 0);
      @(posedge clk);
      #1;
      e.s = 64'h300; e.c = 1'b0; e.o = 1'b0; e.acc = hs + 1;
      sb.push_back(e);
      in_valid = 1'b0;
      drain();

      // Reset in the middle of RUN at idx=2.
      issue(64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
            64'h0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < int'(NS) + 2; i++) begin
         @(negedge clk);
         chk("midrst_no_valid", out_valid, 0);
      end
      @(posedge clk);
      #1;
      op(64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0);

      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
